// File: rtl/seq_pattern_gen_if.sv
// ---------------------------------------------------------------------------
// seq_pattern_gen_if
// Bundle of request and serial-output signals for the serial pattern
// transmitter.
//   Start   : transmit request, taken only while the transmitter is idle
//   Pattern : WIDTH-bit pattern, sent MSB first
//   Reps    : number of transmissions (0 gives an immediate Done)
//   Out1    : serial data bit, forced to 0 whenever Valid is low
//   Valid   : Out1 carries a pattern bit
//   Busy    : transmitter is not idle
//   Done    : single-cycle pulse at the end of a request
// Modports: master drives the request side, slave is the transmitter.
// ---------------------------------------------------------------------------
interface seq_pattern_gen_if #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 4
);
    logic             Start;
    logic [WIDTH-1:0] Pattern;
    logic [CNT_W-1:0] Reps;
    logic             Out1;
    logic             Valid;
    logic             Busy;
    logic             Done;

    modport master (
        output Start, Pattern, Reps,
        input  Out1, Valid, Busy, Done
    );

    modport slave (
        input  Start, Pattern, Reps,
        output Out1, Valid, Busy, Done
    );
endinterface

// File: rtl/seq_pattern_gen.sv
// ---------------------------------------------------------------------------
// seq_pattern_gen
// Serial pattern transmitter. A Start taken in IDLE captures Pattern and
// Reps; the pattern is then shifted out MSB first, one bit per clock, with a
// single Valid=0 gap cycle between repetitions, followed by a one-cycle Done.
// Ports:
//   CLK : clock, rising edge
//   RST : asynchronous active-low reset
//   bus : seq_pattern_gen_if.slave (Start/Pattern/Reps in,
//         Out1/Valid/Busy/Done out)
// All outputs come from registers only; nothing on the request side reaches
// an output without passing through a flop.
// ---------------------------------------------------------------------------
module seq_pattern_gen #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 4
) (
    input  logic              CLK,
    input  logic              RST,
    seq_pattern_gen_if.slave  bus
);
    localparam int              BW       = (WIDTH > 2) ? $clog2(WIDTH) : 1;
    localparam logic [BW-1:0]   LAST_BIT = BW'(WIDTH - 1);
    localparam logic [BW-1:0]   BIT_ONE  = BW'(1);
    localparam logic [CNT_W-1:0] REP_ONE = CNT_W'(1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        GAP   = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t           state_reg;
    logic [WIDTH-1:0] pat_reg;
    logic [WIDTH-1:0] sh_reg;
    logic [BW-1:0]    bit_cnt_reg;
    logic [CNT_W-1:0] rep_cnt_reg;
    logic             valid_reg;
    logic             busy_reg;
    logic             done_reg;

    // The flag registers are loaded with the value belonging to the state
    // being entered, so they always agree with state_reg.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_reg   <= IDLE;
            pat_reg     <= '0;
            sh_reg      <= '0;
            bit_cnt_reg <= '0;
            rep_cnt_reg <= '0;
            valid_reg   <= 1'b0;
            busy_reg    <= 1'b0;
            done_reg    <= 1'b0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (bus.Start) begin
                        busy_reg <= 1'b1;
                        if (bus.Reps != '0) begin
                            pat_reg     <= bus.Pattern;
                            sh_reg      <= bus.Pattern;
                            rep_cnt_reg <= bus.Reps;
                            bit_cnt_reg <= '0;
                            valid_reg   <= 1'b1;
                            state_reg   <= SHIFT;
                        end else begin
                            done_reg  <= 1'b1;
                            state_reg <= DONE;
                        end
                    end
                end

                SHIFT: begin
                    sh_reg      <= {sh_reg[WIDTH-2:0], 1'b0};
                    bit_cnt_reg <= bit_cnt_reg + BIT_ONE;
                    if (bit_cnt_reg == LAST_BIT) begin
                        // Last bit of this repetition is on the line now.
                        rep_cnt_reg <= rep_cnt_reg - REP_ONE;
                        bit_cnt_reg <= '0;
                        valid_reg   <= 1'b0;
                        if (rep_cnt_reg == REP_ONE) begin
                            done_reg  <= 1'b1;
                            state_reg <= DONE;
                        end else begin
                            // Reload now so SHIFT resumes straight from the MSB.
                            sh_reg    <= pat_reg;
                            state_reg <= GAP;
                        end
                    end
                end

                GAP: begin
                    valid_reg <= 1'b1;
                    state_reg <= SHIFT;
                end

                DONE: begin
                    done_reg  <= 1'b0;
                    busy_reg  <= 1'b0;
                    state_reg <= IDLE;
                end

                default: begin
                    valid_reg <= 1'b0;
                    busy_reg  <= 1'b0;
                    done_reg  <= 1'b0;
                    state_reg <= IDLE;
                end
            endcase
        end
    end

    // Gating by valid_reg keeps Out1 at 0 in GAP, where sh_reg already holds
    // the reloaded pattern.
    assign bus.Out1  = valid_reg & sh_reg[WIDTH-1];
    assign bus.Valid = valid_reg;
    assign bus.Busy  = busy_reg;
    assign bus.Done  = done_reg;

endmodule

// File: tb/tb_seq_pattern_gen.sv
// ---------------------------------------------------------------------------
// tb_seq_pattern_gen
// Drives directed and random requests into seq_pattern_gen. Each accepted
// request is expanded by a timing model into the absolute clock edge and
// value of every serial bit, the Done edge and the Busy window. A monitor
// compares the DUT against those expectations on every falling edge.
// ---------------------------------------------------------------------------
module tb_seq_pattern_gen;
    localparam int W  = 8;
    localparam int CW = 4;

    logic CLK = 1'b0;
    logic RST = 1'b0;

    seq_pattern_gen_if #(.WIDTH(W), .CNT_W(CW)) bus ();

    seq_pattern_gen #(.WIDTH(W), .CNT_W(CW)) dut (
        .CLK (CLK),
        .RST (RST),
        .bus (bus.slave)
    );

    always #5 CLK = ~CLK;

    // Index of the most recent rising edge; "the cycle after edge N" is N.
    int cyc = 0;
    always @(posedge CLK) cyc = cyc + 1;

    typedef struct {
        int   edge_n;
        logic b;
    } bit_item_t;

    bit_item_t exp_q[$];
    int        done_q[$];
    int        busy_start = -100;
    int        busy_last  = -100;

    int n_pass  = 0;
    int n_total = 0;

    task automatic check(input bit ok, input string name, input int act, input int req);
        n_total++;
        if (ok) n_pass++;
        else $display("FAIL %s at cycle %0d: got %0d, expected %0d", name, cyc, act, req);
    endtask

    // Timing model: request accepted at edge e produces bit k of repetition
    // r after edge e + r*(W+1) + k, and Done after the last Busy edge.
    task automatic model_accept(input int e, input logic [W-1:0] p, input logic [CW-1:0] r);
        int reps;
        bit_item_t it;
        reps       = int'(r);
        busy_start = e;
        busy_last  = (reps == 0) ? e : e + reps * (W + 1) - 1;
        done_q.push_back(busy_last);
        for (int rr = 0; rr < reps; rr++) begin
            for (int k = 0; k < W; k++) begin
                it.edge_n = e + rr * (W + 1) + k;
                it.b      = p[W-1-k];
                exp_q.push_back(it);
            end
        end
    endtask

    // A Start is accepted only if the transmitter was idle in the cycle
    // before the edge that samples it.
    task automatic drive(input logic s, input logic [W-1:0] p, input logic [CW-1:0] r);
        int e;
        @(negedge CLK);
        #1;
        bus.Start   = s;
        bus.Pattern = p;
        bus.Reps    = r;
        e = cyc + 1;
        if (s && RST && e >= busy_last + 2) model_accept(e, p, r);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(1'b0, bus.Pattern, bus.Reps);
    endtask

    task automatic check_outputs_zero(input string tag);
        check(bus.Out1  === 1'b0, {tag, "_out1"},  int'(bus.Out1),  0);
        check(bus.Valid === 1'b0, {tag, "_valid"}, int'(bus.Valid), 0);
        check(bus.Busy  === 1'b0, {tag, "_busy"},  int'(bus.Busy),  0);
        check(bus.Done  === 1'b0, {tag, "_done"},  int'(bus.Done),  0);
    endtask

    // Monitor
    bit_item_t mon_it;
    logic      exp_busy;
    int        mon_done;
    always @(negedge CLK) begin
        if (RST === 1'b1) begin
            exp_busy = (cyc >= busy_start && cyc <= busy_last);
            check(bus.Busy === exp_busy, "busy", int'(bus.Busy), int'(exp_busy));

            if (bus.Valid === 1'b1) begin
                if (exp_q.size() == 0) begin
                    check(1'b0, "unexpected_bit", cyc, -1);
                end else begin
                    mon_it = exp_q.pop_front();
                    check(mon_it.edge_n == cyc, "bit_time", cyc, mon_it.edge_n);
                    check(bus.Out1 === mon_it.b, "bit_value", int'(bus.Out1), int'(mon_it.b));
                end
            end else begin
                check(bus.Out1 === 1'b0, "out1_when_invalid", int'(bus.Out1), 0);
                if (exp_q.size() > 0 && exp_q[0].edge_n <= cyc) begin
                    check(1'b0, "missed_bit", cyc, exp_q[0].edge_n);
                    void'(exp_q.pop_front());
                end
            end

            if (bus.Done === 1'b1) begin
                if (done_q.size() == 0) begin
                    check(1'b0, "unexpected_done", cyc, -1);
                end else begin
                    mon_done = done_q.pop_front();
                    check(mon_done == cyc, "done_time", cyc, mon_done);
                end
            end else if (done_q.size() > 0 && done_q[0] <= cyc) begin
                check(1'b0, "missed_done", cyc, done_q[0]);
                void'(done_q.pop_front());
            end
        end
    end

    initial begin
        bus.Start   = 1'b0;
        bus.Pattern = '0;
        bus.Reps    = '0;
        #3;
        check_outputs_zero("reset_init");
        @(negedge CLK);
        @(negedge CLK);
        #1;
        RST = 1'b1;

        // Single transmission
        drive(1'b1, 8'hA5, 4'd1);
        idle(12);

        // Repeats with gaps
        drive(1'b1, 8'hC0, 4'd3);
        idle(32);

        // Zero repetitions
        drive(1'b1, 8'h3C, 4'd0);
        idle(4);

        // Start while busy with changed inputs must be ignored
        drive(1'b1, 8'hF0, 4'd1);
        idle(2);
        drive(1'b1, 8'h0F, 4'd5);
        drive(1'b0, 8'h0F, 4'd5);
        idle(12);

        // Back-to-back with Start held high
        for (int i = 0; i < 30; i++) drive(1'b1, 8'h81, 4'd1);
        idle(12);

        // Random traffic
        for (int i = 0; i < 300; i++) begin
            drive(($urandom_range(0, 3) == 0), W'($urandom), CW'($urandom_range(0, 4)));
        end
        idle(45);

        // Asynchronous reset in the middle of SHIFT
        drive(1'b1, 8'hFF, 4'd3);
        idle(5);
        @(posedge CLK);
        #3;
        RST = 1'b0;
        #1;
        check_outputs_zero("reset_mid");
        exp_q.delete();
        done_q.delete();
        busy_start  = -100;
        busy_last   = -100;
        bus.Start   = 1'b0;
        @(negedge CLK);
        @(negedge CLK);
        #1;
        RST = 1'b1;
        idle(15);

        // Recovery after reset
        drive(1'b1, 8'h5A, 4'd2);
        idle(25);

        check(exp_q.size() == 0, "bits_outstanding", exp_q.size(), 0);
        check(done_q.size() == 0, "done_outstanding", done_q.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
